// File: rtl/pma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pma_pkg                                                         |
// | Purpose  : Shared types and constants for the runtime PMA region table.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pma_pkg;

  localparam int unsigned PMA_PLEN = 56;

  typedef struct packed {
    logic nonidem;
    logic cached;
    logic exec;
  } pma_attr_t;

  // Field widths track PMA_PLEN; the table's PlenWidth defaults to the same value.
  typedef struct packed {
    logic [PMA_PLEN-1:0] base;
    logic [PMA_PLEN-1:0] length;
    logic                lock;
    pma_attr_t           attr;
  } pma_rule_t;

  typedef enum logic [1:0] {
    PMA_BASE   = 2'd0,
    PMA_LENGTH = 2'd1,
    PMA_ATTR   = 2'd2
  } pma_field_e;

  localparam pma_attr_t PMA_DEFAULT_ATTR = 3'b010;

endpackage
`default_nettype wire

// File: rtl/pma_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pma_match                                                       |
// | Purpose  : Combinational region match for one address with lowest-index    |
// |            priority encoding.                                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pma_match #(
  parameter int unsigned NrRules     = 8,
  parameter int unsigned PlenWidth   = 56,
  parameter logic [2:0]  DefaultAttr = 3'b010,
  localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic [PlenWidth-1:0] addr_i,
  input  logic [PlenWidth-1:0] base_i [NrRules],
  input  logic [PlenWidth-1:0] len_i  [NrRules],
  input  logic [2:0]           attr_i [NrRules],
  output logic                 hit_o,
  output logic [IdxW-1:0]      rule_o,
  output logic [2:0]           attr_o
);

  logic [NrRules-1:0] w_match;

  // End address is one bit wider so a region reaching the top of space never wraps.
  for (genvar i = 0; i < NrRules; i++) begin : g_rule
    logic [PlenWidth:0] w_end;
    assign w_end      = {1'b0, base_i[i]} + {1'b0, len_i[i]};
    assign w_match[i] = (len_i[i] != '0) && (addr_i >= base_i[i]) &&
                        ({1'b0, addr_i} < w_end);
  end

  always_comb begin
    hit_o  = 1'b0;
    rule_o = '0;
    attr_o = DefaultAttr;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        hit_o  = 1'b1;
        rule_o = IdxW'(i);
        attr_o = attr_i[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pma_region_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pma_region_table                                                |
// | Purpose  : Runtime-programmable PMA table with a config port and NrPorts   |
// |            single-stage lookup channels.                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pma_region_table
  import pma_pkg::*;
#(
  parameter int unsigned                  NrRules     = 8,
  parameter int unsigned                  NrPorts     = 2,
  parameter int unsigned                  PlenWidth   = PMA_PLEN,
  parameter logic [NrRules*PlenWidth-1:0] RstBase     = '0,
  parameter logic [NrRules*PlenWidth-1:0] RstLength   = '0,
  parameter logic [NrRules*4-1:0]         RstAttr     = '0,
  parameter logic [2:0]                   DefaultAttr = PMA_DEFAULT_ATTR,
  localparam int unsigned                 IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [IdxW-1:0]              cfg_idx_i,
  input  logic [1:0]                   cfg_field_i,
  input  logic [PlenWidth-1:0]         cfg_wdata_i,
  output logic                         cfg_rvalid_o,
  output logic [PlenWidth-1:0]         cfg_rdata_o,
  output logic                         cfg_err_o,
  input  logic [NrPorts-1:0]           lkp_valid_i,
  input  logic [NrPorts*PlenWidth-1:0] lkp_addr_i,
  output logic [NrPorts-1:0]           lkp_valid_o,
  output logic [NrPorts*3-1:0]         lkp_attr_o,
  output logic [NrPorts-1:0]           lkp_hit_o,
  output logic [NrPorts*IdxW-1:0]      lkp_rule_o
);

  localparam logic [IdxW:0] C_NR_RULES = (IdxW+1)'(NrRules);

  pma_rule_t             r_rules [NrRules];
  logic [PlenWidth-1:0]  w_base  [NrRules];
  logic [PlenWidth-1:0]  w_len   [NrRules];
  logic [2:0]            w_attr  [NrRules];

  pma_field_e            w_field;
  pma_rule_t             w_sel;
  logic                  w_idx_ok;
  logic                  w_field_ok;
  logic                  w_cfg_err;
  logic                  w_wr_en;
  logic [PlenWidth-1:0]  w_rd_val;

  logic                  r_cfg_rvalid;
  logic                  r_cfg_err;
  logic [PlenWidth-1:0]  r_cfg_rdata;

  assign w_field    = pma_field_e'(cfg_field_i);
  assign w_idx_ok   = ({1'b0, cfg_idx_i} < C_NR_RULES);
  assign w_field_ok = (cfg_field_i != 2'd3);
  assign w_sel      = w_idx_ok ? r_rules[cfg_idx_i] : '0;
  // A locked rule refuses every write, including one that would clear the lock.
  assign w_cfg_err  = !w_idx_ok || !w_field_ok || (cfg_we_i && w_sel.lock);
  assign w_wr_en    = cfg_req_i && cfg_we_i && !w_cfg_err;

  always_comb begin
    w_rd_val = '0;
    case (w_field)
      PMA_BASE:   w_rd_val = w_sel.base;
      PMA_LENGTH: w_rd_val = w_sel.length;
      PMA_ATTR:   w_rd_val = PlenWidth'({w_sel.lock, w_sel.attr});
      default:    w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        r_rules[i].base   <= RstBase[i*PlenWidth +: PlenWidth];
        r_rules[i].length <= RstLength[i*PlenWidth +: PlenWidth];
        r_rules[i].lock   <= RstAttr[i*4 + 3];
        r_rules[i].attr   <= pma_attr_t'(RstAttr[i*4 +: 3]);
      end
    end else if (w_wr_en) begin
      case (w_field)
        PMA_BASE:   r_rules[cfg_idx_i].base   <= cfg_wdata_i;
        PMA_LENGTH: r_rules[cfg_idx_i].length <= cfg_wdata_i;
        PMA_ATTR: begin
          r_rules[cfg_idx_i].lock <= cfg_wdata_i[3];
          r_rules[cfg_idx_i].attr <= pma_attr_t'(cfg_wdata_i[2:0]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg_rvalid <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_cfg_rdata  <= '0;
    end else begin
      r_cfg_rvalid <= cfg_req_i;
      r_cfg_err    <= cfg_req_i && w_cfg_err;
      r_cfg_rdata  <= (cfg_req_i && !cfg_we_i && !w_cfg_err) ? w_rd_val : '0;
    end
  end

  assign cfg_rvalid_o = r_cfg_rvalid;
  assign cfg_err_o    = r_cfg_err;
  assign cfg_rdata_o  = r_cfg_rdata;

  for (genvar i = 0; i < NrRules; i++) begin : g_rule
    assign w_base[i] = r_rules[i].base;
    assign w_len[i]  = r_rules[i].length;
    assign w_attr[i] = r_rules[i].attr;
  end

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic            w_hit;
    logic [IdxW-1:0] w_rule;
    logic [2:0]      w_pattr;
    logic            r_valid;
    logic            r_hit;
    logic [IdxW-1:0] r_rule;
    logic [2:0]      r_attr;

    pma_match #(
      .NrRules     (NrRules),
      .PlenWidth   (PlenWidth),
      .DefaultAttr (DefaultAttr)
    ) u_match (
      .addr_i (lkp_addr_i[p*PlenWidth +: PlenWidth]),
      .base_i (w_base),
      .len_i  (w_len),
      .attr_i (w_attr),
      .hit_o  (w_hit),
      .rule_o (w_rule),
      .attr_o (w_pattr)
    );

    // Result fields hold across idle cycles; only the strobe tracks the input every cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= 1'b0;
        r_hit   <= 1'b0;
        r_rule  <= '0;
        r_attr  <= '0;
      end else begin
        r_valid <= lkp_valid_i[p];
        if (lkp_valid_i[p]) begin
          r_hit  <= w_hit;
          r_rule <= w_rule;
          r_attr <= w_pattr;
        end
      end
    end

    assign lkp_valid_o[p]              = r_valid;
    assign lkp_hit_o[p]                = r_hit;
    assign lkp_rule_o[p*IdxW +: IdxW]  = r_rule;
    assign lkp_attr_o[p*3 +: 3]        = r_attr;
  end

endmodule
`default_nettype wire

// File: tb/tb_pma_region_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pma_region_table                                             |
// | Purpose  : Scoreboard bench for pma_region_table against a table model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pma_region_table;

  localparam int NR = 8;
  localparam int NP = 2;
  localparam int PW = 56;
  localparam logic [NR*PW-1:0] RST_LEN = {{((NR-1)*PW){1'b0}}, 56'h1000};

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            cfg_req_i = 1'b0, cfg_we_i = 1'b0;
  logic [2:0]      cfg_idx_i = '0;
  logic [1:0]      cfg_field_i = '0;
  logic [PW-1:0]   cfg_wdata_i = '0;
  logic            cfg_rvalid_o, cfg_err_o;
  logic [PW-1:0]   cfg_rdata_o;
  logic [NP-1:0]   lkp_valid_i = '0;
  logic [NP*PW-1:0] lkp_addr_i = '0;
  logic [NP-1:0]   lkp_valid_o, lkp_hit_o;
  logic [NP*3-1:0] lkp_attr_o, lkp_rule_o;

  always #5 clk = ~clk;

  pma_region_table #(
    .NrRules(NR), .NrPorts(NP), .PlenWidth(PW),
    .RstBase('0), .RstLength(RST_LEN), .RstAttr('0), .DefaultAttr(3'b010)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .lkp_valid_i(lkp_valid_i), .lkp_addr_i(lkp_addr_i),
    .lkp_valid_o(lkp_valid_o), .lkp_attr_o(lkp_attr_o),
    .lkp_hit_o(lkp_hit_o), .lkp_rule_o(lkp_rule_o)
  );

  typedef struct { logic [PW-1:0] rdata; logic err; } cfg_exp_t;
  typedef struct { logic [2:0] attr; logic hit; logic [2:0] rule; } lkp_exp_t;

  cfg_exp_t cq[$];
  lkp_exp_t lq0[$];
  lkp_exp_t lq1[$];

  logic [PW-1:0] m_base [NR];
  logic [PW-1:0] m_len  [NR];
  logic [2:0]    m_attr [NR];
  logic          m_lock [NR];

  int tests = 0;
  int fails = 0;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = '0; m_len[i] = (i == 0) ? 56'h1000 : '0;
      m_attr[i] = '0; m_lock[i] = 1'b0;
    end
  endtask

  // Lowest index whose [base, base+len) contains addr; len==0 covers nothing.
  function automatic lkp_exp_t model_lookup(logic [PW-1:0] addr);
    lkp_exp_t e;
    e.hit = 1'b0; e.rule = 3'd0; e.attr = 3'b010;
    for (int i = 0; i < NR; i++) begin
      if (m_len[i] != 0 && addr >= m_base[i] && (addr - m_base[i]) < m_len[i]) begin
        e.hit = 1'b1; e.rule = i[2:0]; e.attr = m_attr[i];
        break;
      end
    end
    return e;
  endfunction

  function automatic cfg_exp_t model_cfg(logic we, int idx, int fld);
    cfg_exp_t e;
    e.err = (fld == 3) || (we && m_lock[idx]);
    e.rdata = '0;
    if (!e.err && !we) begin
      case (fld)
        0: e.rdata = m_base[idx];
        1: e.rdata = m_len[idx];
        default: e.rdata = {52'b0, m_lock[idx], m_attr[idx]};
      endcase
    end
    return e;
  endfunction

  task automatic check_lkp(int p, ref lkp_exp_t q[$]);
    lkp_exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL lkp%0d_unexpected: got a strobe, required none", p);
    end else begin
      e = q.pop_front();
      if (lkp_hit_o[p] !== e.hit || lkp_rule_o[p*3 +: 3] !== e.rule || lkp_attr_o[p*3 +: 3] !== e.attr) begin
        fails++;
        $display("FAIL lkp%0d_result: got hit=%b rule=%0d attr=%b, required hit=%b rule=%0d attr=%b",
                 p, lkp_hit_o[p], lkp_rule_o[p*3 +: 3], lkp_attr_o[p*3 +: 3], e.hit, e.rule, e.attr);
      end
    end
  endtask

  // Monitor: samples on the falling edge, pops only when the DUT strobes.
  initial begin
    cfg_exp_t ce;
    forever begin
      @(negedge clk);
      if (cfg_rvalid_o === 1'b1) begin
        tests++;
        if (cq.size() == 0) begin
          fails++;
          $display("FAIL cfg_unexpected: got a strobe, required none");
        end else begin
          ce = cq.pop_front();
          if (cfg_rdata_o !== ce.rdata || cfg_err_o !== ce.err) begin
            fails++;
            $display("FAIL cfg_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                     cfg_rdata_o, cfg_err_o, ce.rdata, ce.err);
          end
        end
      end
      if (lkp_valid_o[0] === 1'b1) check_lkp(0, lq0);
      if (lkp_valid_o[1] === 1'b1) check_lkp(1, lq1);
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic step(logic creq, logic cwe, int cidx, int cfld, logic [PW-1:0] cwd,
                      logic v0, logic [PW-1:0] a0, logic v1, logic [PW-1:0] a1);
    cfg_exp_t ce;
    cfg_req_i = creq; cfg_we_i = cwe; cfg_idx_i = cidx[2:0];
    cfg_field_i = cfld[1:0]; cfg_wdata_i = cwd;
    lkp_valid_i = {v1, v0}; lkp_addr_i = {a1, a0};
    ce = model_cfg(cwe, cidx, cfld);
    if (creq) cq.push_back(ce);
    if (v0) lq0.push_back(model_lookup(a0));
    if (v1) lq1.push_back(model_lookup(a1));
    @(posedge clk); #1;
    if (creq && cwe && !ce.err) begin
      case (cfld)
        0: m_base[cidx] = cwd;
        1: m_len[cidx]  = cwd;
        default: begin m_lock[cidx] = cwd[3]; m_attr[cidx] = cwd[2:0]; end
      endcase
    end
    cfg_req_i = 1'b0; lkp_valid_i = '0;
  endtask

  task automatic wr(int idx, int fld, logic [PW-1:0] d);
    step(1'b1, 1'b1, idx, fld, d, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cfg_req_i = 1'b1; cfg_we_i = 1'b0; lkp_valid_i = '1;
    @(posedge clk); #1;
    model_reset();
    rst_i = 1'b0; cfg_req_i = 1'b0; lkp_valid_i = '0;
    @(posedge clk); #1;
    chk("rst_cfg_rvalid", 64'(cfg_rvalid_o), 64'd0);
    chk("rst_cfg_rdata",  64'(cfg_rdata_o),  64'd0);
    chk("rst_cfg_err",    64'(cfg_err_o),    64'd0);
    chk("rst_lkp_valid",  64'(lkp_valid_o),  64'd0);
    chk("rst_lkp_attr",   64'(lkp_attr_o),   64'd0);
    chk("rst_lkp_hit",    64'(lkp_hit_o),    64'd0);
    chk("rst_lkp_rule",   64'(lkp_rule_o),   64'd0);
  endtask

  initial begin
    logic [PW-1:0] a0, a1, d;
    int fld;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    step(1'b1, 1'b0, 0, 1, '0, 1'b0, '0, 1'b0, '0);
    wr(2, 0, 56'h8000_0000); wr(2, 1, 56'h4000_0000); wr(2, 2, 56'h3);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1, 56'hBFFF_FFFF, 1'b1, 56'hC000_0000);
    wr(1, 0, 56'h1000); wr(1, 1, 56'h1000); wr(1, 2, 56'h1);
    wr(3, 0, 56'h0);    wr(3, 1, 56'h10000); wr(3, 2, 56'h6);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1, 56'h1800, 1'b1, 56'h3000);
    step(1'b1, 1'b0, 5, 3, '0, 1'b0, '0, 1'b0, '0);
    wr(0, 2, 56'h8); wr(0, 0, 56'h5);
    step(1'b1, 1'b0, 0, 0, '0, 1'b0, '0, 1'b0, '0);
    do_reset();
    wr(0, 0, 56'h5);
    wr(0, 0, 56'h2000);
    step(1'b1, 1'b1, 0, 0, 56'h100, 1'b0, '0, 1'b1, 56'h100);
    step(1'b0, 1'b0, 0, 0, '0, 1'b0, '0, 1'b1, 56'h100);
    wr(7, 0, 56'hFF_FFFF_FFFF_F000); wr(7, 1, 56'h1000); wr(7, 2, 56'h5);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1, 56'hFF_FFFF_FFFF_FFFF, 1'b1, 56'hFF_FFFF_FFFF_EFFF);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1, 56'h20000, 1'b1, 56'hFF_FFFF_FFFF_F000);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      fld = $urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2);
      if (fld == 0)      d = 56'($urandom_range(0, 31)) << 12;
      else if (fld == 1) d = 56'($urandom_range(0, 7)) << 12;
      else               d = {52'b0, ($urandom_range(0, 15) == 0), 3'($urandom)};
      a0 = ($urandom_range(0, 19) == 0) ? 56'hFF_FFFF_FFFF_FFFF : 56'($urandom_range(0, 32'h21000));
      a1 = 56'($urandom_range(0, 32'h21000));
      step(1'($urandom), 1'($urandom), $urandom_range(0, 7), fld, d,
           1'($urandom), a0, 1'($urandom), a1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain_cfg",  64'(cq.size()),  64'd0);
    chk("drain_lkp0", 64'(lq0.size()), 64'd0);
    chk("drain_lkp1", 64'(lq1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
